display_serializer: RTL
=======================

DISPLAY_SERIALIZER -- requirements
Module: display_serializer

Interface
REQ-001 Parameter DATA_W, default 8, width of each display word (2..32) SHALL be honoured.
REQ-002 Parameter DEPTH, default 4, FIFO depth in words (power of 2, 2..16) SHALL be honoured.
REQ-003 Parameter CNT_W, default 3, SHALL equal $clog2(DEPTH)+1.
REQ-004 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  SHALL mean a word is offered on data_in.
REQ-007 Port in_ready  output  1  SHALL mean the FIFO can accept a word this cycle.
REQ-008 Port data_in  input  DATA_W  SHALL carry the offered display word.
REQ-009 Port msb_first  input  1  SHALL select bit order; 1 = MSB first, 0 = LSB first.
REQ-010 Port ser_out  output  1  SHALL carry the serial data bit, registered.
REQ-011 Port ser_valid  output  1  SHALL be high exactly while ser_out carries a frame bit.
REQ-012 Port frame_done  output  1  SHALL pulse one cycle after each completed frame.
REQ-013 Port fifo_count  output  CNT_W  SHALL report words currently stored (0..DEPTH).

Function
REQ-014 A push SHALL occur on a cycle with in_valid=1 and in_ready=1; data_in is written at that edge.
REQ-015 in_ready SHALL be 1 iff fifo_count < DEPTH; a word offered while full is not stored and in_valid is ignored.
REQ-016 Push and pop on the same edge SHALL leave fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-017 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-018 IDLE: if fifo_count > 0 -> LOAD, else stay; ser_valid=0, ser_out=0.
REQ-019 LOAD (1 cycle): pop head word into shift register, latch msb_first into a frame-mode register, clear bit counter -> SHIFT.
REQ-020 SHIFT: for DATA_W consecutive cycles, ser_out SHALL present bits in latched order with ser_valid=1; counter increments each cycle; after bit DATA_W-1 -> DONE.
REQ-021 Changes to msb_first during SHIFT SHALL NOT affect the frame in progress.
REQ-022 DONE (1 cycle): ser_valid=0, ser_out=0, frame_done=1 -> IDLE.
REQ-023 Latency: word pushed at edge N into empty FIFO with FSM in IDLE SHALL present its first bit (ser_valid=1) after edge N+3 (N+1 LOAD, N+2 first SHIFT register update occurs at N+3's preceding edge per REQ-020); frame period SHALL be DATA_W+3 cycles (IDLE, LOAD, DATA_W SHIFT, DONE).
REQ-024 Back-to-back words SHALL be serialised in push order with no word lost or duplicated.
REQ-025 A pop SHALL occur only in LOAD, never on an empty FIFO.

Reset
REQ-026 While rst=0: in_ready=1 after release, ser_out=0, ser_valid=0, frame_done=0, fifo_count=0, FSM=IDLE, pointers=0, shift register=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a frame_done pulse and discard all stored words.
REQ-028 First push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-029 FSM state encodings and the default DATA_W/DEPTH constants SHALL live in shared package display_pkg.
REQ-030 The FIFO SHALL be a separate sub-module display_fifo (storage, pointers, count, full/empty); the FSM and shift register stay in display_serializer.

Verification
REQ-031 DATA_W=8, msb_first=1, push 8'hA5 into empty block -> ser_out 1,0,1,0,0,1,0,1 with ser_valid=1 for 8 cycles, then one frame_done pulse.
REQ-032 msb_first=0, push 8'h01 -> first serial bit 1, next seven 0; toggling msb_first mid-frame changes nothing.
REQ-033 DEPTH=4, push 8'h11,22,33,44,55 back-to-back -> 5th offer sees in_ready=0 after 4th push (or LOAD pop frees one slot per REQ-016), all accepted words emerge in order, fifo_count never exceeds 4.
REQ-034 Push while FSM in SHIFT with FIFO non-full -> simultaneous push/pop in the following LOAD keeps fifo_count correct; frames stream with exactly DATA_W+3 cycles spacing.
REQ-035 Assert rst low at bit 4 of a frame with 2 words queued -> outputs zero immediately, no frame_done, fifo_count=0; after release, new word 8'hFF serialises normally.

Source files
------------

// File: rtl/display_pkg.sv
// Shared state encoding and default sizing for the display serializer.
package display_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDepth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/display_fifo.sv
// Word FIFO feeding the serializer: storage, wrapping pointers and occupancy count.
module display_fifo
    import display_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/display_serializer.sv
// Buffers display words and shifts each one out as a framed serial stream,
// in MSB-first or LSB-first order as selected when the frame is loaded.
module display_serializer
    import display_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              msb_first,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_done,
    output logic [CNT_W-1:0]  fifo_count
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic              frame_msb_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign in_ready = !fifo_full;
    assign pop      = (state_q == StLoad) && !fifo_empty;

    display_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (data_in),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outputs are registered, so each SHIFT cycle's bit appears one cycle after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            frame_msb_q <= 1'b0;
            bit_cnt_q   <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) state_q <= StLoad;
                end
                StLoad: begin
                    shreg_q     <= head;
                    frame_msb_q <= msb_first;
                    bit_cnt_q   <= '0;
                    state_q     <= StShift;
                end
                StShift: begin
                    ser_valid <= 1'b1;
                    if (frame_msb_q) begin
                        ser_out <= shreg_q[DATA_W-1];
                        shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                    end else begin
                        ser_out <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[DATA_W-1:1]};
                    end
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) state_q <= StDone;
                end
                StDone: begin
                    frame_done <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
